sdram_access_arbiter: RTL and testbench

Shares the single SDRAM controller port between two requesters: the Pico SPI path (address-load, word read and word write pulses) and the disk-emulation datapath (sector word reads and writes during 2310 operations).
Assembles the 24-bit SPI word address from three sequential byte loads and auto-increments it after each SPI access.
Prefetches the next SPI read word so read data is always ready for register 0x88 reads.
Sits between spi_interface / sector datapath and the SDRAM controller.

---
 rtl/sdram_access_arbiter_pkg.sv | 19 +
 rtl/sdram_access_arbiter_if.sv | 23 ++
 rtl/sdram_access_arbiter_spi_addr_seq.sv | 121 ++++++++++++
 rtl/sdram_access_arbiter.sv | 129 ++++++++++++
 tb/tb_sdram_access_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sdram_access_arbiter_pkg.sv
// Shared types and defaults for the SDRAM access arbiter: widths, FSM state
// encoding and the grant identifier used for round-robin fairness.
package sdram_arb_pkg;

    localparam int ADDR_W_DEF = 24;
    localparam int DATA_W_DEF = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DRV_ACC = 2'd1,
        SPI_ACC = 2'd2
    } arb_state_e;

    typedef enum logic {
        DRV = 1'b0,
        SPI = 1'b1
    } grant_e;

endpackage

// File: rtl/sdram_access_arbiter_if.sv
// Request/acknowledge bus between the arbiter (master) and the SDRAM
// controller (slave). req is a level held until the one-cycle ack.
interface sdram_access_arbiter_if #(
    parameter int ADDR_W = 24,
    parameter int DATA_W = 16
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              ack;
    logic [DATA_W-1:0] rdata;

    modport master (
        output req, we, addr, wdata,
        input  ack, rdata
    );

    modport slave (
        input  req, we, addr, wdata,
        output ack, rdata
    );
endinterface

// File: rtl/sdram_access_arbiter_spi_addr_seq.sv
// SPI side of the arbiter: assembles the word address from byte loads,
// auto-increments it and holds the single-entry SPI request queue.
module spi_addr_seq
    import sdram_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              load_address_spi,
    input  logic [7:0]        spi_serpar_reg,
    input  logic              rd_pulse,
    input  logic              wr_pulse,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              spi_inflight,
    input  logic              spi_done,
    output logic [ADDR_W-1:0] spi_addr,
    output logic              spi_pend,
    output logic              spi_pend_we,
    output logic [DATA_W-1:0] spi_pend_wdata,
    output logic              spi_overrun
);

    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [1:0]        cnt_q, cnt_d;
    logic              pend_q, pend_d;
    logic              pend_we_q, pend_we_d;
    logic [DATA_W-1:0] pend_wdata_q, pend_wdata_d;
    logic              overrun_q, overrun_d;
    logic              refetch_q, refetch_d;
    logic              addr_inc;
    logic              third_load;

    assign third_load = load_address_spi && (cnt_q == 2'd2);

    always_comb begin
        addr_d       = addr_q;
        cnt_d        = cnt_q;
        pend_d       = pend_q;
        pend_we_d    = pend_we_q;
        pend_wdata_d = pend_wdata_q;
        overrun_d    = overrun_q;
        refetch_d    = refetch_q;
        addr_inc     = 1'b0;

        if (load_address_spi) begin
            cnt_d = (cnt_q == 2'd2) ? 2'd0 : cnt_q + 2'd1;
        end

        // A read re-armed during its own flight is re-queued on completion.
        if (spi_done) begin
            pend_d    = refetch_q;
            pend_we_d = 1'b0;
            refetch_d = 1'b0;
            addr_inc  = pend_we_q;
        end

        if (wr_pulse) begin
            if (pend_q) begin
                overrun_d = 1'b1;
            end else begin
                pend_d       = 1'b1;
                pend_we_d    = 1'b1;
                pend_wdata_d = wr_data;
                if (rd_pulse) overrun_d = 1'b1;
            end
        end else if (rd_pulse) begin
            if (pend_q) begin
                overrun_d = 1'b1;
            end else begin
                pend_d    = 1'b1;
                pend_we_d = 1'b0;
                addr_inc  = 1'b1;
            end
        end else if (third_load) begin
            if (!pend_q) begin
                pend_d    = 1'b1;
                pend_we_d = 1'b0;
            end else if (!pend_we_q && spi_inflight) begin
                // A queued read latches the new address at grant anyway;
                // only an in-flight read needs to be repeated.
                if (spi_done) pend_d = 1'b1;
                else          refetch_d = 1'b1;
            end
        end

        if (load_address_spi) begin
            addr_d = {addr_q[ADDR_W-9:0], spi_serpar_reg};
        end else if (addr_inc) begin
            addr_d = addr_q + ADDR_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            addr_q       <= '0;
            cnt_q        <= 2'd0;
            pend_q       <= 1'b0;
            pend_we_q    <= 1'b0;
            pend_wdata_q <= '0;
            overrun_q    <= 1'b0;
            refetch_q    <= 1'b0;
        end else begin
            addr_q       <= addr_d;
            cnt_q        <= cnt_d;
            pend_q       <= pend_d;
            pend_we_q    <= pend_we_d;
            pend_wdata_q <= pend_wdata_d;
            overrun_q    <= overrun_d;
            refetch_q    <= refetch_d;
        end
    end

    assign spi_addr       = addr_q;
    assign spi_pend       = pend_q;
    assign spi_pend_we    = pend_we_q;
    assign spi_pend_wdata = pend_wdata_q;
    assign spi_overrun    = overrun_q;

endmodule

// File: rtl/sdram_access_arbiter.sv
// Shares one SDRAM controller port between the SPI path and the disk
// datapath; SPI is guaranteed to wait behind at most one drive access.
module sdram_access_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 load_address_spi,
    input  logic [7:0]           spi_serpar_reg,
    input  logic                 dram_read_enbl_spi,
    input  logic                 dram_write_enbl_spi,
    input  logic [DATA_W-1:0]    dram_writedata_spi,
    output logic [DATA_W-1:0]    dram_readdata,
    input  logic                 drv_req,
    input  logic                 drv_we,
    input  logic [ADDR_W-1:0]    drv_addr,
    input  logic [DATA_W-1:0]    drv_wdata,
    output logic                 drv_ack,
    output logic [DATA_W-1:0]    drv_rdata,
    sdram_access_arbiter_if.master mem,
    output logic                 spi_busy,
    output logic                 spi_overrun
);

    arb_state_e        state_q;
    grant_e            last_grant_q;
    logic              mem_req_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic              drv_ack_q;
    logic [DATA_W-1:0] drv_rdata_q;
    logic [DATA_W-1:0] dram_readdata_q;

    logic [ADDR_W-1:0] spi_addr;
    logic              spi_pend;
    logic              spi_pend_we;
    logic [DATA_W-1:0] spi_pend_wdata;
    logic              spi_done;
    logic              drv_eligible;

    assign spi_done = (state_q == SPI_ACC) && mem.ack;
    // drv_req is still high during its own ack cycle; don't re-grant it then.
    assign drv_eligible = drv_req && !drv_ack_q;

    spi_addr_seq #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) u_spi_addr_seq (
        .clock            (clock),
        .reset            (reset),
        .load_address_spi (load_address_spi),
        .spi_serpar_reg   (spi_serpar_reg),
        .rd_pulse         (dram_read_enbl_spi),
        .wr_pulse         (dram_write_enbl_spi),
        .wr_data          (dram_writedata_spi),
        .spi_inflight     (state_q == SPI_ACC),
        .spi_done         (spi_done),
        .spi_addr         (spi_addr),
        .spi_pend         (spi_pend),
        .spi_pend_we      (spi_pend_we),
        .spi_pend_wdata   (spi_pend_wdata),
        .spi_overrun      (spi_overrun)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q         <= IDLE;
            last_grant_q    <= DRV;
            mem_req_q       <= 1'b0;
            mem_we_q        <= 1'b0;
            mem_addr_q      <= '0;
            mem_wdata_q     <= '0;
            drv_ack_q       <= 1'b0;
            drv_rdata_q     <= '0;
            dram_readdata_q <= '0;
        end else begin
            drv_ack_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (spi_pend && (last_grant_q == DRV || !drv_eligible)) begin
                        mem_addr_q   <= spi_addr;
                        mem_we_q     <= spi_pend_we;
                        mem_wdata_q  <= spi_pend_wdata;
                        mem_req_q    <= 1'b1;
                        last_grant_q <= SPI;
                        state_q      <= SPI_ACC;
                    end else if (drv_eligible) begin
                        mem_addr_q   <= drv_addr;
                        mem_we_q     <= drv_we;
                        mem_wdata_q  <= drv_wdata;
                        mem_req_q    <= 1'b1;
                        last_grant_q <= DRV;
                        state_q      <= DRV_ACC;
                    end
                end
                DRV_ACC: begin
                    if (mem.ack) begin
                        mem_req_q <= 1'b0;
                        drv_ack_q <= 1'b1;
                        if (!mem_we_q) drv_rdata_q <= mem.rdata;
                        state_q   <= IDLE;
                    end
                end
                SPI_ACC: begin
                    if (mem.ack) begin
                        mem_req_q <= 1'b0;
                        if (!mem_we_q) dram_readdata_q <= mem.rdata;
                        state_q   <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign mem.req       = mem_req_q;
    assign mem.we        = mem_we_q;
    assign mem.addr      = mem_addr_q;
    assign mem.wdata     = mem_wdata_q;
    assign drv_ack       = drv_ack_q;
    assign drv_rdata     = drv_rdata_q;
    assign dram_readdata = dram_readdata_q;
    assign spi_busy      = spi_pend | (state_q == SPI_ACC);

endmodule

// File: tb/tb_sdram_access_arbiter.sv
// Directed bench for sdram_access_arbiter with a latency-programmable
// controller model that logs every issued access.
module tb_sdram_access_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        load_address_spi;
    logic [7:0]  spi_serpar_reg;
    logic        dram_read_enbl_spi;
    logic        dram_write_enbl_spi;
    logic [15:0] dram_writedata_spi;
    logic [15:0] dram_readdata;
    logic        drv_req;
    logic        drv_we;
    logic [23:0] drv_addr;
    logic [15:0] drv_wdata;
    logic        drv_ack;
    logic [15:0] drv_rdata;
    logic        spi_busy;
    logic        spi_overrun;

    sdram_access_arbiter_if #(.ADDR_W(24), .DATA_W(16)) mif ();

    sdram_access_arbiter #(.ADDR_W(24), .DATA_W(16)) dut (
        .clock               (clock),
        .reset               (reset),
        .load_address_spi    (load_address_spi),
        .spi_serpar_reg      (spi_serpar_reg),
        .dram_read_enbl_spi  (dram_read_enbl_spi),
        .dram_write_enbl_spi (dram_write_enbl_spi),
        .dram_writedata_spi  (dram_writedata_spi),
        .dram_readdata       (dram_readdata),
        .drv_req             (drv_req),
        .drv_we              (drv_we),
        .drv_addr            (drv_addr),
        .drv_wdata           (drv_wdata),
        .drv_ack             (drv_ack),
        .drv_rdata           (drv_rdata),
        .mem                 (mif.master),
        .spi_busy            (spi_busy),
        .spi_overrun         (spi_overrun)
    );

    always #12.5 clock = ~clock;

    int          n_checks = 0;
    int          n_errors = 0;
    int          lat = 2;
    bit          hold = 1'b0;
    logic [15:0] rdata_val = 16'h0000;
    int          n_drv_ack = 0;
    logic [23:0] log_addr[$];
    logic        log_we[$];
    logic [15:0] log_wdata[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Controller model: acks after lat cycles of req unless held.
    initial begin
        int  cnt;
        bit  req_prev;
        cnt = 0;
        req_prev = 1'b0;
        mif.ack = 1'b0;
        mif.rdata = 16'h0;
        forever begin
            @(negedge clock);
            mif.ack = 1'b0;
            if (mif.req === 1'b1 && !reset) begin
                if (!req_prev) begin
                    log_addr.push_back(mif.addr);
                    log_we.push_back(mif.we);
                    log_wdata.push_back(mif.wdata);
                end
                cnt++;
                if (cnt >= lat && !hold) begin
                    mif.ack = 1'b1;
                    mif.rdata = rdata_val;
                    cnt = 0;
                end
            end else begin
                cnt = 0;
            end
            req_prev = (mif.req === 1'b1) && !reset;
        end
    end

    initial begin
        forever begin
            @(negedge clock);
            if (drv_ack === 1'b1) n_drv_ack++;
        end
    end

    task automatic pulse_load(input logic [7:0] b);
        @(negedge clock);
        load_address_spi = 1'b1;
        spi_serpar_reg = b;
        @(negedge clock);
        load_address_spi = 1'b0;
    endtask

    task automatic load_addr(input logic [23:0] a);
        pulse_load(a[23:16]);
        pulse_load(a[15:8]);
        pulse_load(a[7:0]);
    endtask

    task automatic pulse_rd();
        @(negedge clock);
        dram_read_enbl_spi = 1'b1;
        @(negedge clock);
        dram_read_enbl_spi = 1'b0;
    endtask

    task automatic pulse_wr(input logic [15:0] d);
        @(negedge clock);
        dram_write_enbl_spi = 1'b1;
        dram_writedata_spi = d;
        @(negedge clock);
        dram_write_enbl_spi = 1'b0;
    endtask

    task automatic wait_spi_done(input string tag);
        for (int i = 0; i < 200 && spi_busy !== 1'b0; i++) @(negedge clock);
        check_eq({tag, "_idle"}, spi_busy, 1'b0);
    endtask

    task automatic wait_log(input string tag, input int n);
        for (int i = 0; i < 200 && log_addr.size() < n; i++) @(negedge clock);
        check_eq({tag, "_issued"}, log_addr.size() >= n, 1'b1);
    endtask

    task automatic check_log(input string tag, input int idx, input logic [23:0] a,
                             input logic we, input logic [15:0] wd);
        if (idx < log_addr.size()) begin
            check_eq({tag, "_addr"}, log_addr[idx], a);
            check_eq({tag, "_we"}, log_we[idx], we);
            if (we) check_eq({tag, "_wdata"}, log_wdata[idx], wd);
        end else begin
            check_eq({tag, "_present"}, log_addr.size(), idx + 1);
        end
    endtask

    initial begin
        int base;
        reset = 1'b1;
        load_address_spi = 1'b0;
        spi_serpar_reg = 8'h0;
        dram_read_enbl_spi = 1'b0;
        dram_write_enbl_spi = 1'b0;
        dram_writedata_spi = 16'h0;
        drv_req = 1'b0;
        drv_we = 1'b0;
        drv_addr = 24'h0;
        drv_wdata = 16'h0;
        repeat (3) @(negedge clock);
        check_eq("rst_mem_req", mif.req, 1'b0);
        check_eq("rst_readdata", dram_readdata, 16'h0);
        check_eq("rst_drv_ack", drv_ack, 1'b0);
        check_eq("rst_busy", spi_busy, 1'b0);
        check_eq("rst_overrun", spi_overrun, 1'b0);
        reset = 1'b0;

        // Address assembly and prefetch
        rdata_val = 16'hBEEF;
        base = log_addr.size();
        load_addr(24'h012345);
        wait_spi_done("pf1");
        check_log("pf1", base, 24'h012345, 1'b0, 16'h0);
        check_eq("pf1_readdata", dram_readdata, 16'hBEEF);
        check_eq("pf1_count", log_addr.size(), base + 1);

        // Read pulse pre-increments, writes post-increment
        rdata_val = 16'h1010;
        load_addr(24'h000010);
        wait_spi_done("pf2");
        rdata_val = 16'hA5A5;
        base = log_addr.size();
        pulse_rd();
        wait_spi_done("rd1");
        check_log("rd1", base, 24'h000011, 1'b0, 16'h0);
        check_eq("rd1_readdata", dram_readdata, 16'hA5A5);
        rdata_val = 16'hDEAD;
        pulse_wr(16'h1111);
        wait_spi_done("wr1");
        pulse_wr(16'h2222);
        wait_spi_done("wr2");
        check_log("wr1", base + 1, 24'h000011, 1'b1, 16'h1111);
        check_log("wr2", base + 2, 24'h000012, 1'b1, 16'h2222);
        check_eq("wr_readdata_kept", dram_readdata, 16'hA5A5);

        // Address wrap
        rdata_val = 16'h0F0F;
        base = log_addr.size();
        load_addr(24'hFFFFFF);
        wait_spi_done("pf3");
        pulse_rd();
        wait_spi_done("wrap");
        check_log("pf3", base, 24'hFFFFFF, 1'b0, 16'h0);
        check_log("wrap", base + 1, 24'h000000, 1'b0, 16'h0);

        // Drive held busy, SPI write slots in between two drive accesses
        lat = 4;
        rdata_val = 16'h7777;
        n_drv_ack = 0;
        base = log_addr.size();
        @(negedge clock);
        drv_addr = 24'h00ABCD;
        drv_we = 1'b0;
        drv_req = 1'b1;
        wait_log("drv1", base + 1);
        pulse_wr(16'h3333);
        wait_log("drv3", base + 3);
        for (int i = 0; i < 50 && drv_ack !== 1'b1; i++) @(negedge clock);
        check_eq("drv_ack_seen", drv_ack, 1'b1);
        drv_req = 1'b0;
        repeat (10) @(negedge clock);
        check_log("fair_drv1", base, 24'h00ABCD, 1'b0, 16'h0);
        check_log("fair_spi", base + 1, 24'h000000, 1'b1, 16'h3333);
        check_log("fair_drv2", base + 2, 24'h00ABCD, 1'b0, 16'h0);
        check_eq("fair_count", log_addr.size(), base + 3);
        check_eq("drv_ack_count", n_drv_ack, 2);
        check_eq("drv_rdata", drv_rdata, 16'h7777);

        // Overrun while an SPI read is stalled
        lat = 2;
        hold = 1'b1;
        rdata_val = 16'h4242;
        base = log_addr.size();
        pulse_rd();
        wait_log("ovr", base + 1);
        pulse_rd();
        repeat (20) @(negedge clock);
        hold = 1'b0;
        wait_spi_done("ovr");
        repeat (5) @(negedge clock);
        check_eq("ovr_flag", spi_overrun, 1'b1);
        check_eq("ovr_count", log_addr.size(), base + 1);
        check_log("ovr", base, 24'h000002, 1'b0, 16'h0);
        check_eq("ovr_readdata", dram_readdata, 16'h4242);

        // Reset mid-access
        hold = 1'b1;
        base = log_addr.size();
        pulse_rd();
        wait_log("rstacc", base + 1);
        check_eq("rstacc_req_high", mif.req, 1'b1);
        reset = 1'b1;
        @(negedge clock);
        check_eq("rstacc_mem_req", mif.req, 1'b0);
        check_eq("rstacc_readdata", dram_readdata, 16'h0);
        check_eq("rstacc_busy", spi_busy, 1'b0);
        check_eq("rstacc_overrun", spi_overrun, 1'b0);
        reset = 1'b0;
        hold = 1'b0;
        rdata_val = 16'h1234;
        base = log_addr.size();
        pulse_rd();
        wait_spi_done("post_rd");
        check_log("post_rd", base, 24'h000001, 1'b0, 16'h0);
        check_eq("post_rd_readdata", dram_readdata, 16'h1234);
        rdata_val = 16'h5678;
        load_addr(24'h000100);
        wait_spi_done("post_pf");
        check_log("post_pf", base + 1, 24'h000100, 1'b0, 16'h0);
        check_eq("post_pf_readdata", dram_readdata, 16'h5678);

        // Simultaneous read and write pulses: write wins, overrun set
        rdata_val = 16'h9999;
        base = log_addr.size();
        @(negedge clock);
        dram_read_enbl_spi = 1'b1;
        dram_write_enbl_spi = 1'b1;
        dram_writedata_spi = 16'h4444;
        @(negedge clock);
        dram_read_enbl_spi = 1'b0;
        dram_write_enbl_spi = 1'b0;
        wait_spi_done("simul");
        repeat (5) @(negedge clock);
        check_log("simul", base, 24'h000100, 1'b1, 16'h4444);
        check_eq("simul_count", log_addr.size(), base + 1);
        check_eq("simul_overrun", spi_overrun, 1'b1);
        check_eq("simul_readdata", dram_readdata, 16'h5678);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got 0x0 expected 0x1");
        $fatal(1, "timeout");
    end

endmodule
